// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sequencer.
package tts_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } tts_state_e;

  // Depth of the truth table for a function with n_in inputs.
  function automatic int unsigned table_w(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Host/function-side bundle of the truth-table sequencer.
interface truth_table_sequencer_if
  import tts_pkg::*;
#(
  parameter int unsigned N_IN = 2
) ();

  localparam int unsigned TableW = table_w(N_IN);

  logic              start;
  logic              abort;
  logic [TableW-1:0] expected;
  logic              s_in;
  logic [N_IN-1:0]   vec;
  logic              busy;
  logic              done;
  logic [TableW-1:0] table_out;
  logic              match;
  logic [N_IN-1:0]   first_fail;
  logic              fail_valid;

  // Host plus function under test.
  modport master (
    output start, abort, expected, s_in,
    input  vec, busy, done, table_out, match, first_fail, fail_valid
  );

  modport slave (
    input  start, abort, expected, s_in,
    output vec, busy, done, table_out, match, first_fail, fail_valid
  );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter; zero flags the end of a vector's settle window.
module settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CntW = $clog2(SETTLE + 1);
  // Loading SETTLE-1 makes zero assert on the SETTLE-th cycle after load.
  localparam logic [CntW-1:0] LoadVal = CntW'(SETTLE - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LoadVal;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all input vectors of a combinational block, captures its output
// into a table and compares it against a golden table.
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input logic                     clk,
  input logic                     reset,
  truth_table_sequencer_if.slave  bus
);

  localparam int unsigned       TableW  = table_w(N_IN);
  localparam logic [N_IN-1:0]   LastIdx = '1;
  localparam tts_state_e        StVec   = (SETTLE == 0) ? StCapture : StWait;

  tts_state_e        state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [TableW-1:0] exp_q, exp_d;
  logic [TableW-1:0] table_q, table_d;
  logic [N_IN-1:0]   first_fail_q, first_fail_d;
  logic              fail_valid_q, fail_valid_d;
  logic              match_q, match_d;
  logic              timer_load, timer_dec, settle_zero;

  if (SETTLE > 0) begin : g_timer
    settle_timer #(
      .SETTLE (SETTLE)
    ) u_settle_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .dec   (timer_dec),
      .zero  (settle_zero)
    );
  end else begin : g_no_timer
    logic unused_timer;
    assign unused_timer = timer_load ^ timer_dec;
    assign settle_zero  = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    exp_d        = exp_q;
    table_d      = table_q;
    first_fail_d = first_fail_q;
    fail_valid_d = fail_valid_q;
    match_d      = match_q;
    timer_load   = 1'b0;
    timer_dec    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          exp_d        = bus.expected;
          table_d      = '0;
          first_fail_d = '0;
          fail_valid_d = 1'b0;
          match_d      = 1'b0;
          idx_d        = '0;
          timer_load   = 1'b1;
          state_d      = StVec;
        end
      end
      StWait, StCapture: begin
        if (bus.abort) begin
          state_d      = StIdle;
          idx_d        = '0;
          table_d      = '0;
          first_fail_d = '0;
          fail_valid_d = 1'b0;
          match_d      = 1'b0;
        end else if (state_q == StWait) begin
          if (settle_zero) begin
            state_d = StCapture;
          end else begin
            timer_dec = 1'b1;
          end
        end else begin
          table_d[idx_q] = bus.s_in;
          // Only the lowest failing index is recorded.
          if ((bus.s_in != exp_q[idx_q]) && !fail_valid_q) begin
            first_fail_d = idx_q;
            fail_valid_d = 1'b1;
          end
          if (idx_q == LastIdx) begin
            state_d = StDone;
            match_d = (table_d == exp_q);
          end else begin
            idx_d      = idx_q + 1'b1;
            timer_load = 1'b1;
            state_d    = StVec;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      exp_q        <= '0;
      table_q      <= '0;
      first_fail_q <= '0;
      fail_valid_q <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      exp_q        <= exp_d;
      table_q      <= table_d;
      first_fail_q <= first_fail_d;
      fail_valid_q <= fail_valid_d;
      match_q      <= match_d;
    end
  end

  assign bus.vec        = idx_q;
  assign bus.busy       = (state_q == StWait) || (state_q == StCapture);
  assign bus.done       = (state_q == StDone);
  assign bus.table_out  = table_q;
  assign bus.match      = match_q;
  assign bus.first_fail = first_fail_q;
  assign bus.fail_valid = fail_valid_q;

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Sequencer that exercises a combinational function block (e.g. module f, s = ~x & y) in hardware, replacing a hand-written stimulus list.
- Sweeps all 2**N_IN input vectors in ascending order and waits a programmable settle time for each.
- Samples the function output into a result table and compares it bit-by-bit against an expected table.
- Sits between a control/host interface (start/abort/done) and the function under test.

Parameters:
N_IN, 2, number of function inputs; vector width; table depth = 2**N_IN
SETTLE, 1, idle cycles between driving a vector and sampling s_in (0 allowed)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a sweep; honoured only in IDLE
abort  input  1  cancel a running sweep
expected  input  2**N_IN  golden table; bit i = expected output for vector i; latched on accepted start
s_in  input  1  output of function under test
vec  output  N_IN  drives function inputs; vec[N_IN-1] is MSB (for f: vec[1]=x, vec[0]=y)
busy  output  1  high from accepted start until DONE is entered
done  output  1  one-cycle pulse on sweep completion
table_out  output  2**N_IN  captured results; bit i = s_in sampled for vector i
match  output  1  table_out == latched expected; valid when done pulses; held afterwards
first_fail  output  N_IN  lowest index with a mismatch; 0 if none
fail_valid  output  1  at least one mismatch in the last completed sweep

Behaviour:
Reset values (async, immediate):
- state=IDLE; vec, table_out, first_fail = 0; busy, done, match, fail_valid = 0; exp_q = 0.

States: IDLE, WAIT, CAPTURE, DONE.
- IDLE: busy=0. On start=1:
  - latch expected into exp_q; clear table_out, fail_valid, first_fail, match; idx=0.
  - go to WAIT with settle count = SETTLE, or straight to CAPTURE if SETTLE=0.
- WAIT: count down; after SETTLE cycles go to CAPTURE.
- CAPTURE (1 cycle):
  - table_out[idx] <= s_in.
  - If s_in != exp_q[idx] and fail_valid=0: first_fail <= idx, fail_valid <= 1.
  - If idx == 2**N_IN-1: go to DONE. Otherwise idx++ and reload WAIT (or CAPTURE if SETTLE=0).
- DONE (1 cycle): done=1, busy=0, match = (table_out == exp_q). Next state is IDLE.

Signal rules:
- vec = idx at all times; it is registered and changes only on the edge that leaves CAPTURE.
- Each vector is held for SETTLE+1 cycles before sampling.

Latency:
- DONE is entered 2**N_IN*(SETTLE+1) cycles after the edge that accepts start.
- Example: N_IN=2, SETTLE=1 gives 8 cycles.

Boundary conditions:
- start while busy or in DONE: ignored; exp_q is not re-latched.
- abort=1 in WAIT/CAPTURE: next state IDLE; no done pulse; vec=0; table_out, match and fail_valid cleared. abort in IDLE/DONE is ignored, and DONE still pulses.
- abort and start in the same IDLE cycle: abort wins; sweep not started.
- reset mid-sweep: all outputs return to reset values asynchronously; no done pulse.
- idx wrap: the last index never increments; the counter is N_IN+1 bits wide or uses an explicit terminal compare (no overflow to 0).
- Outputs (table_out, match, first_fail, fail_valid) hold until the next accepted start, abort or reset.

Decomposition:
- Shared package tts_pkg holds:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, CAPTURE=2'd2, DONE=2'd3);
  - TABLE_W function (2**N_IN).
- One sub-module, settle_timer: load/count-down/zero flag, width clog2(SETTLE+1); bypassed when SETTLE=0.

Test Plan:
1. N_IN=2, SETTLE=1, bench drives s_in from f(vec[1],vec[0]), expected=4'b0010, start pulse -> vec steps 0,1,2,3 holding 2 cycles each; done pulses 8 cycles after start edge; table_out=4'b0010, match=1, fail_valid=0.
2. Same DUT, expected=4'b0110 -> table_out=4'b0010, match=0, fail_valid=1, first_fail=2'd2.
3. SETTLE=0, expected=4'b0010 -> vec changes every cycle; done 4 cycles after start; match=1.
4. Start a sweep, assert abort during vector 2 -> returns to IDLE next cycle, no done pulse, vec=0, table_out=0, busy=0; a new start then completes normally.
5. Assert reset asynchronously mid-WAIT (between edges) -> all outputs 0 immediately; start re-pulsed during busy of a following sweep is ignored (done occurs once, at the original latency).
6. Start and abort in the same IDLE cycle -> busy stays 0, no sweep; start asserted during the DONE cycle -> ignored, IDLE follows.
